maxval_int: RTL and testbench

//  PL accelerator that finds the largest 32-bit word in a 2048-word on-chip BRAM and writes it back to word 0.
//  PS fills the BRAM through an AXI-BRAM-controller style port (ps_bram_*), pulses start via ps_control[0] and polls pl_status[0].

---
 rtl/maxval_pkg.sv | 21 ++
 rtl/maxval_bram_tdp.sv | 44 ++++
 rtl/maxval_int.sv | 137 +++++++++++++
 tb/tb_maxval_int.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxval_pkg.sv
// Shared constants and FSM state encoding for the maxval_int accelerator.
// Build option: define MAXVAL_SIGNED_EN for a two's-complement compare instead of unsigned.
package maxval_pkg;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int BYTES   = DATA_W / 8;
    localparam int PS_AW   = ADDR_W + 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAST  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/maxval_bram_tdp.sv
// True-dual-port word RAM: port A has byte enables (PS side), port B writes whole words (scan side).
// Both ports are read-first with a registered read; a same-edge, same-word write from B overrides A.
module maxval_bram_tdp
    import maxval_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic              clk,

    input  logic              en_a,
    input  logic [DW/8-1:0]   we_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [DW-1:0]     wrdata_a,
    output logic [DW-1:0]     rddata_a,

    input  logic              en_b,
    input  logic              we_b,
    input  logic [AW-1:0]     addr_b,
    input  logic [DW-1:0]     wrdata_b,
    output logic [DW-1:0]     rddata_b
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Port B is written after port A so its assignment is the one that lands on a collision.
    always_ff @(posedge clk) begin
        if (en_a) begin
            rddata_a <= mem[addr_a];
            for (int i = 0; i < DW / 8; i++) begin
                if (we_a[i]) begin
                    mem[addr_a][8*i +: 8] <= wrdata_a[8*i +: 8];
                end
            end
        end
        if (en_b) begin
            rddata_b <= mem[addr_b];
            if (we_b) begin
                mem[addr_b] <= wrdata_b;
            end
        end
    end

endmodule

// File: rtl/maxval_int.sv
// Scans a 2048-word BRAM for its largest word and writes that word back to address 0.
// Build option: MAXVAL_SIGNED_EN switches the compare from unsigned to two's-complement signed.
module maxval_int
    import maxval_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ps_control,
    output logic [31:0]       pl_status,
    input  logic              ps_bram_clk,
    input  logic [12:0]       ps_bram_addr,
    output logic [31:0]       ps_bram_rddata,
    input  logic [31:0]       ps_bram_wrdata,
    input  logic [3:0]        ps_bram_we,
    input  logic              ps_bram_en
);

    function automatic logic is_greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MAXVAL_SIGNED_EN
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        return sa > sb;
`else
        return a > b;
`endif
    endfunction

    logic                start;
    state_t              state;
    state_t              state_nx;

    logic [ADDR_W-1:0]   cnt_p0;
    logic                vld_p0;
    logic                vld_p1;
    logic [ADDR_W-1:0]   idx_p1;
    logic [DATA_W-1:0]   rd_p1;
    logic [DATA_W-1:0]   max_p2;
    logic                done_r;

    logic                en_b;
    logic                we_b;
    logic [ADDR_W-1:0]   addr_b;

    logic                unused_ok;

    assign start     = ps_control[0];
    assign unused_ok = ^{ps_bram_clk, ps_control[31:1], ps_bram_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt_p0 == LAST_ADDR) state_nx = LAST;
            LAST:    state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: read address issue, one word per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if (state == RUN) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end else begin
            cnt_p0 <= '0;
        end
    end

    assign vld_p0 = (state == RUN);

    // Stage p1: RAM data returns alongside the index it was read from.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1 <= cnt_p0;
    end

    // Stage p2: running maximum; word 0 seeds it so stale values never leak between runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_p2 <= '0;
        end else if (vld_p1 && ((idx_p1 == '0) || is_greater(rd_p1, max_p2))) begin
            max_p2 <= rd_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state == DONE);
        end
    end

    assign pl_status = {31'b0, done_r};

    assign en_b   = (state == RUN) || (state == WRITE);
    assign we_b   = (state == WRITE);
    assign addr_b = (state == WRITE) ? '0 : cnt_p0;

    maxval_bram_tdp #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_bram (
        .clk      (clk),
        .en_a     (ps_bram_en),
        .we_a     (ps_bram_we),
        .addr_a   (ps_bram_addr[12:2]),
        .wrdata_a (ps_bram_wrdata),
        .rddata_a (ps_bram_rddata),
        .en_b     (en_b),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .wrdata_b (max_p2),
        .rddata_b (rd_p1)
    );

endmodule

// File: tb/tb_maxval_int.sv
// Directed/randomized bench for maxval_int with a memory-array reference model.
module tb_maxval_int;

    localparam int NW = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ps_control;
    logic [31:0] pl_status;
    logic [12:0] ps_bram_addr;
    logic [31:0] ps_bram_rddata;
    logic [31:0] ps_bram_wrdata;
    logic [3:0]  ps_bram_we;
    logic        ps_bram_en;

    logic [31:0] model [0:NW-1];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    maxval_int dut (
        .clk            (clk),
        .reset          (reset),
        .ps_control     (ps_control),
        .pl_status      (pl_status),
        .ps_bram_clk    (clk),
        .ps_bram_addr   (ps_bram_addr),
        .ps_bram_rddata (ps_bram_rddata),
        .ps_bram_wrdata (ps_bram_wrdata),
        .ps_bram_we     (ps_bram_we),
        .ps_bram_en     (ps_bram_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic bigger(input logic [31:0] a, input logic [31:0] b);
`ifdef MAXVAL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic logic [31:0] ref_max();
        logic [31:0] m;
        m = model[0];
        for (int i = 1; i < NW; i++) if (bigger(model[i], m)) m = model[i];
        return m;
    endfunction

    // Inputs change 1 time unit after a rising edge; tasks return at that same point.
    task automatic ps_write(input int w, input logic [31:0] d, input logic [3:0] we);
        ps_bram_addr   = {11'(w), 2'($urandom_range(0, 3))};
        ps_bram_wrdata = d;
        ps_bram_we     = we;
        ps_bram_en     = 1'b1;
        @(posedge clk);
        #1;
        ps_bram_en = 1'b0;
        ps_bram_we = 4'h0;
        for (int i = 0; i < 4; i++) if (we[i]) model[w][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic ps_read(input int w, output logic [31:0] d);
        ps_bram_addr = {11'(w), 2'($urandom_range(0, 3))};
        ps_bram_we   = 4'h0;
        ps_bram_en   = 1'b1;
        @(posedge clk);
        #1;
        ps_bram_en = 1'b0;
        d = ps_bram_rddata;
    endtask

    task automatic fill(input int mode);
        logic [31:0] v;
        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            case (mode)
                1: if (i == NW - 1) v = 32'hFFFF_FFFF;
                2: v = (i == 0) ? 32'h8000_0000 : (v & 32'h7FFF_FFFF);
                3: v = 32'h0;
                4: v = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h0000_0005 : 32'h8000_0000;
                default: ;
            endcase
            ps_write(i, v, 4'hF);
        end
    endtask

    task automatic run_latency(input string tag);
        ps_control = 32'h1;
        @(posedge clk);
        repeat (2050) @(posedge clk);
        #1;
        check({tag, "_done_early"}, pl_status, 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_done_on_time"}, pl_status, 32'h1);
    endtask

    task automatic finish_run(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        ps_control = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done_clear"}, pl_status, 32'h0);
        ps_read(0, d);
        check({tag, "_word0"}, d, exp);
        model[0] = exp;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp;
        int          bad;

        reset          = 1'b1;
        ps_control     = 32'h0;
        ps_bram_addr   = '0;
        ps_bram_wrdata = '0;
        ps_bram_we     = 4'h0;
        ps_bram_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", pl_status, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_status", pl_status, 32'h0);

        ps_write(10, 32'h1122_3344, 4'hF);
        ps_write(10, 32'hAABB_CCDD, 4'b0010);
        ps_read(10, d);
        check("byte_enable", d, 32'h1122_CC44);
        check("byte_model", d, model[10]);
        ps_write(11, 32'hCAFE_0011, 4'hF);
        ps_read(11, d);
        ps_bram_addr = 13'd40;
        repeat (2) @(posedge clk);
        #1;
        check("rddata_hold", ps_bram_rddata, 32'hCAFE_0011);

        fill(1);
        exp = ref_max();
        run_latency("t1");
        finish_run("t1", exp);

        fill(0);
        exp = ref_max();
        run_latency("rand");
        finish_run("rand", exp);

        fill(2);
        exp = ref_max();
        run_latency("t2_word0");
        finish_run("t2_word0", exp);

        fill(3);
        run_latency("t2_zero");
        finish_run("t2_zero", 32'h0);

        fill(0);
        exp = ref_max();
        run_latency("t4");
        ps_write(7, bigger(32'hFFFF_FFFF, 32'h7FFF_FFFF) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF, 4'hF);
        bad = 0;
        for (int c = 0; c < 49; c++) begin
            @(posedge clk);
            #1;
            if (pl_status !== 32'h1) bad++;
        end
        check("t4_done_held", 32'(bad), 32'h0);
        finish_run("t4", exp);

        fill(0);
        ps_control = 32'h1;
        repeat (100) @(posedge clk);
        #1;
        reset      = 1'b1;
        ps_control = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_abort_status", pl_status, 32'h0);
        bad = 0;
        for (int c = 0; c < 2100; c++) begin
            @(posedge clk);
            #1;
            if (pl_status !== 32'h0) bad++;
        end
        check("t5_no_done", 32'(bad), 32'h0);
        ps_read(0, d);
        check("t5_word0_kept", d, model[0]);
        ps_read(1234, d);
        check("t5_word1234_kept", d, model[1234]);
        ps_read(2047, d);
        check("t5_word2047_kept", d, model[2047]);

        reset      = 1'b1;
        ps_control = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp   = ref_max();
        run_latency("start_at_release");
        finish_run("start_at_release", exp);

`ifdef MAXVAL_SIGNED_EN
        fill(4);
        exp = ref_max();
        run_latency("t6_signed");
        finish_run("t6_signed", exp);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
